// File: rtl/rr_shared_dff_arbiter.sv
// Round-robin arbiter that sequences N requesters onto one shared WIDTH-bit
// register. Each write is a grant / load / ack sequence lasting 3 cycles.
module rr_shared_dff_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] D,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   Qbar,
  output logic               busy,
  output logic [IDXW-1:0]    owner
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              busy_q, busy_d;

  logic [IDXW-1:0]   win_idx;
  logic              win_found;
  logic [IDXW-1:0]   cand_idx;
  logic [IDXW-1:0]   ptr_inc;

  // Rotating-priority scan starting at ptr; first requester found wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand_idx  = '0;
    for (int unsigned j = 0; j < N; j++) begin
      cand_idx = IDXW'((32'(ptr_q) + j) % N);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign ptr_inc = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          busy_d         = 1'b1;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        if (req[owner_q]) begin
          q_d     = D[owner_q*WIDTH +: WIDTH];
          ack_d   = gnt_q;
          state_d = DONE;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_inc;
          state_d = IDLE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_inc;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign Q     = q_q;
  assign Qbar  = ~q_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_rr_shared_dff_arbiter.sv
// Directed bench for rr_shared_dff_arbiter (N=4, WIDTH=8) with hand-computed
// expectations per scenario plus a per-cycle invariant monitor.
module tb_rr_shared_dff_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] D;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  Q;
  logic [7:0]  Qbar;
  logic        busy;
  logic [1:0]  owner;

  int n_cmp;
  int n_err;

  rr_shared_dff_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .D(D), .gnt(gnt), .ack(ack),
    .Q(Q), .Qbar(Qbar), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (busy !== (gnt != 4'b0) || (ack & ~gnt) != 4'b0 || !$onehot0(gnt) ||
          !$onehot0(ack) || Qbar !== ~Q) begin
        n_err++;
        $display("FAIL invariant t=%0t: gnt=%b ack=%b busy=%b Q=%h Qbar=%h", $time, gnt, ack, busy, Q, Qbar);
      end
    end
  end

  task automatic test_reset();
    n_cmp++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || owner !== 2'd0) begin
      n_err++;
      $display("FAIL reset_init: Q=%h Qbar=%h gnt=%b ack=%b busy=%b owner=%0d, required 00 ff 0000 0000 0 0", Q, Qbar, gnt, ack, busy, owner);
    end
    reset = 1'b0;
    req = 4'b0001; D = 32'h0000_003C;
    tick(); tick(); req = 4'b0000; tick();
    n_cmp++;
    if (Q !== 8'h3C) begin n_err++; $display("FAIL reset_preload: Q=%h required 3c", Q); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || gnt !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL reset_async: Q=%h Qbar=%h gnt=%b busy=%b ack=%b, required 00 ff 0000 0 0000", Q, Qbar, gnt, busy, ack);
    end
    req = 4'b1111;
    tick(); tick();
    n_cmp++;
    if (Q !== 8'h00 || gnt !== 4'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: Q=%h gnt=%b busy=%b, required 00 0000 0", Q, gnt, busy);
    end
    req = 4'b0000;
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    req = 4'b0010; D = 32'h33_22_A5_11;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1 || ack !== 4'b0 || Q !== 8'h00) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b ack=%b Q=%h, required 0010 1 1 0000 00", gnt, owner, busy, ack, Q);
    end
    tick();
    n_cmp++;
    if (Q !== 8'hA5 || Qbar !== 8'h5A || ack !== 4'b0010 || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL single_load: Q=%h Qbar=%h ack=%b gnt=%b, required a5 5a 0010 0010", Q, Qbar, ack, gnt);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (ack !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || Q !== 8'hA5) begin
      n_err++;
      $display("FAIL single_done: ack=%b gnt=%b busy=%b Q=%h, required 0000 0000 0 a5", ack, gnt, busy, Q);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || Q !== 8'hA5) begin
      n_err++;
      $display("FAIL single_hold: gnt=%b busy=%b Q=%h, required 0000 0 a5", gnt, busy, Q);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] idx;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    req = 4'b1111; D = 32'h13_12_11_10;
    for (int t = 0; t < 5; t++) begin
      idx = 2'(t % 4);
      tick();
      n_cmp++;
      if (gnt !== (4'b0001 << idx) || owner !== idx) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: gnt=%b owner=%0d, required %b %0d", t, gnt, owner, 4'b0001 << idx, idx);
      end
      tick();
      n_cmp++;
      if (Q !== (8'h10 + 8'(idx)) || ack !== (4'b0001 << idx)) begin
        n_err++;
        $display("FAIL rr_load[%0d]: Q=%h ack=%b, required %h %b", t, Q, ack, 8'h10 + 8'(idx), 4'b0001 << idx);
      end
      if (t == 4) req = 4'b0000;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || gnt !== 4'b0 || ack !== 4'b0) begin
        n_err++;
        $display("FAIL rr_idle[%0d]: busy=%b gnt=%b ack=%b, required 0 0000 0000", t, busy, gnt, ack);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] reqs [3] = '{4'b1000, 4'b1001, 4'b1001};
    logic [1:0] exp  [3] = '{2'd3, 2'd0, 2'd3};
    D = 32'h43_42_41_40;
    for (int t = 0; t < 3; t++) begin
      req = reqs[t];
      tick();
      n_cmp++;
      if (gnt !== (4'b0001 << exp[t]) || owner !== exp[t]) begin
        n_err++;
        $display("FAIL wrap_grant[%0d]: gnt=%b owner=%0d, required %b %0d", t, gnt, owner, 4'b0001 << exp[t], exp[t]);
      end
      tick();
      n_cmp++;
      if (Q !== (8'h40 + 8'(exp[t])) || ack !== (4'b0001 << exp[t])) begin
        n_err++;
        $display("FAIL wrap_load[%0d]: Q=%h ack=%b, required %h %b", t, Q, ack, 8'h40 + 8'(exp[t]), 4'b0001 << exp[t]);
      end
      req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_abort();
    req = 4'b0100; D = 32'h53_77_51_50;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin n_err++; $display("FAIL abort_grant: gnt=%b required 0100", gnt); end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (Q !== 8'h43 || ack !== 4'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
      n_err++;
      $display("FAIL abort_drop: Q=%h ack=%b busy=%b gnt=%b, required 43 0000 0 0000", Q, ack, busy, gnt);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL abort_next: gnt=%b owner=%0d ack=%b, required 1000 3 0000", gnt, owner, ack);
    end
    tick();
    n_cmp++;
    if (Q !== 8'h53 || ack !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_next_load: Q=%h ack=%b, required 53 1000", Q, ack);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_load();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    req = 4'b0010; D = 32'h63_62_77_60;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || Q !== 8'h00) begin
      n_err++;
      $display("FAIL midload_grant: gnt=%b Q=%h, required 0010 00", gnt, Q);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (Q !== 8'h00 || gnt !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL midload_reset: Q=%h gnt=%b busy=%b ack=%b, required 00 0000 0 0000", Q, gnt, busy, ack);
    end
    tick(); tick();
    n_cmp++;
    if (Q !== 8'h00 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL midload_held: Q=%h ack=%b, required 00 0000", Q, ack);
    end
    req = 4'b1010;
    #2 reset = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      n_err++;
      $display("FAIL midload_ptr: gnt=%b owner=%0d, required 0010 1", gnt, owner);
    end
    tick();
    n_cmp++;
    if (Q !== 8'h77 || ack !== 4'b0010) begin
      n_err++;
      $display("FAIL midload_after_load: Q=%h ack=%b, required 77 0010", Q, ack);
    end
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      n_err++;
      $display("FAIL midload_req2_grant: gnt=%b owner=%0d, required 0100 2", gnt, owner);
    end
    tick();
    n_cmp++;
    if (Q !== 8'h62 || ack !== 4'b0100) begin
      n_err++;
      $display("FAIL midload_req2_load: Q=%h ack=%b, required 62 0100", Q, ack);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 4'b0000;
    D     = '0;
    #12;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap_skip();
    test_abort();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
